// File: rtl/bidir_bus_ctrl_if.sv
// Request/response and pad-side signals of the bidirectional bus controller.
// The slave modport is the controller's view; the master modport is the requester and pad side.
interface bidir_bus_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_wdata;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       pad_oe;
  logic [7:0] pad_wdata;
  logic [7:0] pad_rdata;

  modport slave (
    input  req_valid, req_wr, req_wdata, pad_rdata,
    output req_ready, rd_data, rd_valid, busy, pad_oe, pad_wdata
  );

  modport master (
    output req_valid, req_wr, req_wdata, pad_rdata,
    input  req_ready, rd_data, rd_valid, busy, pad_oe, pad_wdata
  );
endinterface

// File: rtl/bidir_bus_ctrl.sv
// Sequences writes and reads onto a registered bidirectional pad, guaranteeing a
// setup cycle before driving and a turnaround gap after every write.
module bidir_bus_ctrl #(
  parameter int unsigned WR_HOLD    = 2,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  bidir_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WSETUP = 3'd1,
    WDRIVE = 3'd2,
    TURN   = 3'd3,
    RWAIT  = 3'd4
  } state_t;

  localparam logic [3:0] WR_HOLD_LD = 4'(WR_HOLD - 1);
  localparam logic [3:0] TURN_LD    = 4'(TURNAROUND - 1);
  localparam logic [3:0] RD_LAT_LD  = 4'(RD_LAT - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       pad_oe_reg, pad_oe_next;
  logic [7:0] pad_wdata_reg, pad_wdata_next;
  logic [7:0] rd_data_reg, rd_data_next;
  logic       rd_valid_reg, rd_valid_next;
  logic       accept;

  assign accept = bus.req_valid && (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      pad_oe_reg    <= 1'b0;
      pad_wdata_reg <= 8'd0;
      rd_data_reg   <= 8'd0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pad_oe_reg    <= pad_oe_next;
      pad_wdata_reg <= pad_wdata_next;
      rd_data_reg   <= rd_data_next;
      rd_valid_reg  <= rd_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pad_oe_next    = pad_oe_reg;
    pad_wdata_next = pad_wdata_reg;
    rd_data_next   = rd_data_reg;
    rd_valid_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        pad_oe_next = 1'b0;
        if (accept) begin
          if (bus.req_wr) begin
            // Data is loaded a cycle before the pad is enabled so the pad register is settled.
            pad_wdata_next = bus.req_wdata;
            state_next     = WSETUP;
          end else begin
            cnt_next   = RD_LAT_LD;
            state_next = RWAIT;
          end
        end
      end
      WSETUP: begin
        pad_oe_next = 1'b1;
        cnt_next    = WR_HOLD_LD;
        state_next  = WDRIVE;
      end
      WDRIVE: begin
        if (cnt_reg == 4'd0) begin
          pad_oe_next = 1'b0;
          cnt_next    = TURN_LD;
          state_next  = TURN;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      TURN: begin
        pad_oe_next = 1'b0;
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RWAIT: begin
        pad_oe_next = 1'b0;
        if (cnt_reg == 4'd0) begin
          rd_data_next  = bus.pad_rdata;
          rd_valid_next = 1'b1;
          state_next    = IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        pad_oe_next = 1'b0;
        cnt_next    = 4'd0;
        state_next  = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.pad_oe    = pad_oe_reg;
  assign bus.pad_wdata = pad_wdata_reg;
  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_valid  = rd_valid_reg;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed bench: a per-cycle vector table on the default-parameter instance, plus
// hand sequences for reset aborts and a second instance at the parameter extremes.
module tb_bidir_bus_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bidir_bus_ctrl_if bus_d ();
  bidir_bus_ctrl_if bus_x ();

  bidir_bus_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_d.slave)
  );

  bidir_bus_ctrl #(
    .WR_HOLD    (1),
    .TURNAROUND (15),
    .RD_LAT     (15)
  ) u_ext (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_x.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic [7:0] wd;
    logic [7:0] rdat;
    logic       e_rdy;
    logic       e_oe;
    logic [7:0] e_pwd;
    logic       e_rdv;
    logic [7:0] e_rdd;
  } vec_t;

  vec_t vecs [27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    int ready_edge;
    int oe_cnt;
    int first_oe;
    int turn_cyc;
    int cap_edge;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_d.req_valid = 1'b0; bus_d.req_wr = 1'b0; bus_d.req_wdata = 8'h00; bus_d.pad_rdata = 8'h00;
    bus_x.req_valid = 1'b0; bus_x.req_wr = 1'b0; bus_x.req_wdata = 8'h00; bus_x.pad_rdata = 8'h00;

    //                 v     wr    wd     rdat   rdy   oe    pwd    rdv   rdd
    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h3C};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h3C};
    vecs[9]  = '{1'b1, 1'b1, 8'h11, 8'h3C, 1'b0, 1'b0, 8'h11, 1'b0, 8'h3C};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h11, 1'b0, 8'h3C};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h11, 1'b0, 8'h3C};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h11, 1'b0, 8'h3C};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h11, 1'b0, 8'h3C};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h11, 1'b0, 8'h3C};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h11, 1'b0, 8'h3C};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h11, 1'b1, 8'h5A};
    vecs[17] = '{1'b1, 1'b1, 8'h22, 8'h5A, 1'b0, 1'b0, 8'h22, 1'b0, 8'h5A};
    vecs[18] = '{1'b1, 1'b1, 8'h33, 8'h5A, 1'b0, 1'b1, 8'h22, 1'b0, 8'h5A};
    vecs[19] = '{1'b1, 1'b1, 8'h33, 8'h5A, 1'b0, 1'b1, 8'h22, 1'b0, 8'h5A};
    vecs[20] = '{1'b1, 1'b1, 8'h33, 8'h5A, 1'b0, 1'b0, 8'h22, 1'b0, 8'h5A};
    vecs[21] = '{1'b1, 1'b1, 8'h33, 8'h5A, 1'b1, 1'b0, 8'h22, 1'b0, 8'h5A};
    vecs[22] = '{1'b1, 1'b1, 8'h33, 8'h5A, 1'b0, 1'b0, 8'h33, 1'b0, 8'h5A};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h33, 1'b0, 8'h5A};
    vecs[24] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h33, 1'b0, 8'h5A};
    vecs[25] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h33, 1'b0, 8'h5A};
    vecs[26] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h33, 1'b0, 8'h5A};

    // Reset state, checked while rst_n is still low.
    #1;
    chk("rst_ready", 32'(bus_d.req_ready), 32'd1);
    chk("rst_busy",  32'(bus_d.busy),      32'd0);
    chk("rst_oe",    32'(bus_d.pad_oe),    32'd0);
    chk("rst_pwd",   32'(bus_d.pad_wdata), 32'h00);
    chk("rst_rdd",   32'(bus_d.rd_data),   32'h00);
    chk("rst_rdv",   32'(bus_d.rd_valid),  32'd0);
    #11 rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      bus_d.req_valid = vecs[i].v;
      bus_d.req_wr    = vecs[i].wr;
      bus_d.req_wdata = vecs[i].wd;
      bus_d.pad_rdata = vecs[i].rdat;
      @(posedge clk);
      #1;
      $display("vec %0d v=%b wr=%b wd=%h rdy=%b oe=%b pwd=%h rdv=%b rdd=%h", i, vecs[i].v, vecs[i].wr,
               vecs[i].wd, bus_d.req_ready, bus_d.pad_oe, bus_d.pad_wdata, bus_d.rd_valid, bus_d.rd_data);
      chk($sformatf("vec%0d_ready", i), 32'(bus_d.req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_busy", i),  32'(bus_d.busy),      32'(!vecs[i].e_rdy));
      chk($sformatf("vec%0d_oe", i),    32'(bus_d.pad_oe),    32'(vecs[i].e_oe));
      chk($sformatf("vec%0d_pwd", i),   32'(bus_d.pad_wdata), 32'(vecs[i].e_pwd));
      chk($sformatf("vec%0d_rdv", i),   32'(bus_d.rd_valid),  32'(vecs[i].e_rdv));
      chk($sformatf("vec%0d_rdd", i),   32'(bus_d.rd_data),   32'(vecs[i].e_rdd));
    end

    // Reset mid-WDRIVE: pad_oe must drop without waiting for a clock edge.
    bus_d.req_valid = 1'b1; bus_d.req_wr = 1'b1; bus_d.req_wdata = 8'h5C;
    @(posedge clk); #1;
    bus_d.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wdrive_oe", 32'(bus_d.pad_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe",    32'(bus_d.pad_oe),    32'd0);
    chk("arst_ready", 32'(bus_d.req_ready), 32'd1);
    chk("arst_pwd",   32'(bus_d.pad_wdata), 32'h00);
    chk("arst_rdd",   32'(bus_d.rd_data),   32'h00);
    chk("arst_rdv",   32'(bus_d.rd_valid),  32'd0);
    $display("txn reset mid-write oe=%b ready=%b", bus_d.pad_oe, bus_d.req_ready);
    @(posedge clk); #3 rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(bus_d.req_ready), 32'd1);

    // Read accepted on the first edge after release, then aborted by reset before capture.
    bus_d.req_valid = 1'b1; bus_d.req_wr = 1'b0; bus_d.pad_rdata = 8'h99;
    @(posedge clk); #1;
    chk("rel_accept_ready", 32'(bus_d.req_ready), 32'd0);
    bus_d.req_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rrst_ready", 32'(bus_d.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rrst_rdv_hold", 32'(bus_d.rd_valid), 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rrst_rdv%0d", k), 32'(bus_d.rd_valid), 32'd0);
      chk($sformatf("rrst_rdd%0d", k), 32'(bus_d.rd_data),  32'h00);
    end
    $display("txn reset mid-read rdv=%b rdd=%h", bus_d.rd_valid, bus_d.rd_data);

    // Extremes: WR_HOLD=1, TURNAROUND=15, RD_LAT=15.
    bus_x.req_valid = 1'b1; bus_x.req_wr = 1'b1; bus_x.req_wdata = 8'h7E;
    @(posedge clk); #1;
    bus_x.req_valid = 1'b0;
    chk("ext_setup_oe", 32'(bus_x.pad_oe),    32'd0);
    chk("ext_pwd",      32'(bus_x.pad_wdata), 32'h7E);
    ready_edge = 0; oe_cnt = 0; first_oe = 0; turn_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus_x.pad_oe) begin
        oe_cnt++;
        if (first_oe == 0) first_oe = i;
      end
      if (bus_x.req_ready) begin
        ready_edge = i;
        break;
      end
      if (!bus_x.pad_oe && oe_cnt > 0) turn_cyc++;
    end
    $display("txn ext write oe_cycles=%0d turn=%0d ready_edge=%0d", oe_cnt, turn_cyc, ready_edge);
    chk("ext_oe_cycles",  32'(oe_cnt),     32'd1);
    chk("ext_first_oe",   32'(first_oe),   32'd1);
    chk("ext_turn_cyc",   32'(turn_cyc),   32'd15);
    chk("ext_ready_edge", 32'(ready_edge), 32'd17);

    bus_x.req_valid = 1'b1; bus_x.req_wr = 1'b0; bus_x.pad_rdata = 8'hC3;
    @(posedge clk); #1;
    bus_x.req_valid = 1'b0;
    cap_edge = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      chk($sformatf("ext_rwait_oe%0d", i), 32'(bus_x.pad_oe), 32'd0);
      if (bus_x.rd_valid) begin
        cap_edge = i;
        break;
      end
    end
    $display("txn ext read cap_edge=%0d rdd=%h", cap_edge, bus_x.rd_data);
    chk("ext_cap_edge", 32'(cap_edge),      32'd15);
    chk("ext_rdd",      32'(bus_x.rd_data), 32'hC3);
    @(posedge clk); #1;
    chk("ext_rdv_pulse", 32'(bus_x.rd_valid), 32'd0);
    chk("ext_rdd_hold",  32'(bus_x.rd_data),  32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bidir_bus_ctrl.md
BIDIR_BUS_CTRL -- requirements
Module: bidir_bus_ctrl

Interface
REQ-001 The block SHALL have a parameter WR_HOLD, default 2, giving the number of cycles pad_oe is held high per write (legal range 1..15).
REQ-002 The block SHALL have a parameter TURNAROUND, default 1, giving the number of idle cycles with pad_oe low after each write (legal range 1..15).
REQ-003 The block SHALL have a parameter RD_LAT, default 2, giving the number of cycles from read acceptance to rd_data capture (legal range 2..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-008 The block SHALL have port req_wr, input, 1 bit: 1 = write, 0 = read; qualified by req_valid.
REQ-009 The block SHALL have port req_wdata, input, 8 bits: write data; qualified by req_valid & req_wr.
REQ-010 The block SHALL have port rd_data, output, 8 bits: captured read data.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking rd_data as new.
REQ-012 The block SHALL have port busy, output, 1 bit: the block is not in IDLE.
REQ-013 The block SHALL have port pad_oe, output, 1 bit: drives the output-enable of the downstream bidirectional pad register.
REQ-014 The block SHALL have port pad_wdata, output, 8 bits: drives the data input of the pad register.
REQ-015 The block SHALL have port pad_rdata, input, 8 bits: the registered bus sample returned by the pad register.

Function
REQ-016 The block SHALL implement the states IDLE, WSETUP, WDRIVE, TURN and RWAIT in a registered FSM with a 4-bit down-counter.
REQ-017 req_ready SHALL equal (state == IDLE), decoded combinationally from the state register; busy SHALL equal its inverse.
REQ-018 A request SHALL be accepted only on a rising edge where req_valid & req_ready; the requester holds req_* stable until acceptance.
REQ-019 On write acceptance, pad_wdata SHALL load req_wdata and the FSM SHALL enter WSETUP with pad_oe = 0, giving the pad register one cycle to register the data before it is driven.
REQ-020 From WSETUP, the next edge SHALL enter WDRIVE, set pad_oe = 1 and load counter = WR_HOLD-1.
REQ-021 In WDRIVE, the counter SHALL decrement each cycle; at 0 the FSM SHALL enter TURN, clear pad_oe and load counter = TURNAROUND-1.
REQ-022 In TURN, the counter SHALL decrement; at 0 the FSM SHALL enter IDLE.
REQ-023 pad_oe SHALL be high for exactly WR_HOLD consecutive cycles per write, and a write SHALL occupy 1+WR_HOLD+TURNAROUND cycles.
REQ-024 pad_wdata SHALL hold its value from acceptance until the next write is accepted.
REQ-025 On read acceptance, the FSM SHALL enter RWAIT with pad_oe = 0 and load counter = RD_LAT-1.
REQ-026 In RWAIT, the counter SHALL decrement; at 0 the next edge SHALL capture rd_data <= pad_rdata, pulse rd_valid for one cycle and enter IDLE.
REQ-027 rd_data SHALL hold its value between captures.
REQ-028 pad_oe SHALL never be high in IDLE, WSETUP, TURN or RWAIT, so a read can never overlap a driven bus; every write-to-read transition passes through TURN.
REQ-029 Back-to-back requests SHALL be accepted on the first IDLE cycle, giving no extra bubble beyond the state sequence above.
REQ-030 req_valid asserted while busy SHALL have no effect until IDLE.

Reset
REQ-031 While rst_n = 0, the block SHALL immediately set state = IDLE, counter = 0, pad_oe = 0, pad_wdata = 0, rd_data = 0 and rd_valid = 0, independent of clk.
REQ-032 A reset asserted mid-operation SHALL abort the transaction with no rd_valid pulse and release the bus within the same cycle.
REQ-033 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-034 The bench SHALL cover reset: rst_n low mid-WDRIVE -> pad_oe falls asynchronously, req_ready = 1 after release, rd_valid never pulses.
REQ-035 The bench SHALL cover a single write with defaults: write 0xA5 accepted at edge 0 -> pad_wdata = 0xA5 after edge 0, pad_oe high after edges 1-2 (2 cycles), TURN 1 cycle, req_ready high after edge 4.
REQ-036 The bench SHALL cover a single read: read accepted at edge 0 with pad_rdata = 0x3C stable -> rd_data = 0x3C and rd_valid = 1 for exactly the cycle after edge 2.
REQ-037 The bench SHALL cover write then read back-to-back: write 0x11 then read -> pad_oe low for at least TURNAROUND cycles before read acceptance, with no cycle where pad_oe = 1 in RWAIT.
REQ-038 The bench SHALL cover request while busy: req_valid held high during a write -> exactly one acceptance per IDLE visit and req_wdata changes are ignored until acceptance.
REQ-039 The bench SHALL cover parameter extremes: WR_HOLD = 1, TURNAROUND = 15, RD_LAT = 15 -> pad_oe pulse of 1 cycle, 15-cycle turnaround and capture 15 edges after read acceptance.
